vit_acs_sched: RTL and testbench

- Scheduler for a time-multiplexed Viterbi add-compare-select (ACS) datapath in the rate-1/2, 64-state hard-decision decoder.
- Accepts one received bit pair per symbol over a valid/ready handshake.
- Drives the shared branch-metric/ACS bank through GROUPS butterfly groups per symbol and writes survivor bits to the traceback memory.
- Schedules path-metric normalization and traceback requests, one TB_LEN window at a time.

---
 rtl/vit_acs_sched_if.sv | 36 +++
 rtl/vit_acs_sched.sv | 180 ++++++++++++++++++
 tb/tb_vit_acs_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vit_acs_sched_if.sv
// Symbol, ACS-bank, survivor-memory and traceback signals of the Viterbi ACS scheduler.
// master: scheduler side; slave: surrounding datapath / upstream / traceback engine.
interface vit_acs_sched_if #(
  parameter int unsigned GW = 3,
  parameter int unsigned AW = 6
);
  logic          rx_valid;
  logic [1:0]    rx_pair;
  logic          rx_last;
  logic          rx_ready;
  logic [1:0]    acs_pair;
  logic          acs_en;
  logic [GW-1:0] acs_group;
  logic          acs_init;
  logic          acs_norm;
  logic          pm_msb;
  logic          sm_wr_en;
  logic [AW+GW-1:0] sm_wr_addr;
  logic          tb_start;
  logic [AW-1:0] tb_addr;
  logic          tb_final;
  logic          tb_done;
  logic          busy;

  modport master (
    input  rx_valid, rx_pair, rx_last, pm_msb, tb_done,
    output rx_ready, acs_pair, acs_en, acs_group, acs_init, acs_norm,
           sm_wr_en, sm_wr_addr, tb_start, tb_addr, tb_final, busy
  );

  modport slave (
    output rx_valid, rx_pair, rx_last, pm_msb, tb_done,
    input  rx_ready, acs_pair, acs_en, acs_group, acs_init, acs_norm,
           sm_wr_en, sm_wr_addr, tb_start, tb_addr, tb_final, busy
  );
endinterface

// File: rtl/vit_acs_sched.sv
// Scheduler for a time-multiplexed rate-1/2, 64-state Viterbi ACS bank: steps GROUPS
// butterfly groups per symbol, writes survivors, and issues windowed traceback requests.
module vit_acs_sched #(
  parameter int unsigned GROUPS   = 8,
  parameter int unsigned TB_DEPTH = 64,
  parameter int unsigned TB_LEN   = 32
) (
  input logic             clk,
  input logic             rst,
  vit_acs_sched_if.master bus
);
  localparam int unsigned GW = $clog2(GROUPS);
  localparam int unsigned AW = $clog2(TB_DEPTH);
  localparam int unsigned WW = $clog2(TB_LEN + 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(TB_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, TB_REQ, TB_WAIT} state_t;

  state_t        state, state_d;
  logic [GW-1:0] grp, grp_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [WW-1:0] win_cnt, win_cnt_d;
  logic          init_pend, init_pend_d;
  logic          norm_pend, norm_pend_d;
  logic          msb_acc, msb_acc_d;
  logic          last_q, last_d;
  logic [1:0]    pair_q, pair_d;
  logic          tb_due, tb_due_d;
  logic          run_d;

  logic             rx_ready_q, rx_ready_d;
  logic             acs_en_q, acs_en_d;
  logic [GW-1:0]    acs_group_q, acs_group_d;
  logic             acs_init_q, acs_init_d;
  logic             acs_norm_q, acs_norm_d;
  logic             sm_wr_en_q, sm_wr_en_d;
  logic [AW+GW-1:0] sm_wr_addr_q, sm_wr_addr_d;
  logic             tb_start_q, tb_start_d;
  logic [AW-1:0]    tb_addr_q, tb_addr_d;
  logic             tb_final_q, tb_final_d;
  logic             busy_q, busy_d;

  // Window closes on its TB_LEN-th symbol or on the frame's final symbol.
  assign tb_due = (win_cnt == WIN_LAST) | last_q;

  // Next-state and bookkeeping.
  always_comb begin
    state_d     = state;
    grp_d       = grp;
    wr_ptr_d    = wr_ptr;
    win_cnt_d   = win_cnt;
    init_pend_d = init_pend;
    norm_pend_d = norm_pend;
    msb_acc_d   = msb_acc;
    last_d      = last_q;
    pair_d      = pair_q;

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          pair_d  = bus.rx_pair;
          last_d  = bus.rx_last;
          grp_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (grp != GRP_LAST) begin
          grp_d     = grp + 1'b1;
          msb_acc_d = msb_acc | bus.pm_msb;
        end else begin
          // Final-group pm_msb still counts toward the next symbol's normalization.
          wr_ptr_d    = wr_ptr + 1'b1;
          win_cnt_d   = win_cnt + 1'b1;
          init_pend_d = 1'b0;
          norm_pend_d = msb_acc | bus.pm_msb;
          msb_acc_d   = 1'b0;
          if (tb_due) begin
            state_d = TB_REQ;
          end else if (bus.rx_valid) begin
            pair_d = bus.rx_pair;
            last_d = bus.rx_last;
            grp_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TB_REQ: begin
        win_cnt_d = '0;
        if (last_q) begin
          init_pend_d = 1'b1;
          norm_pend_d = 1'b0;
        end
        state_d = TB_WAIT;
      end
      TB_WAIT: begin
        if (bus.tb_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, decoded from the next-state bookkeeping.
  always_comb begin
    run_d        = (state_d == RUN);
    tb_due_d     = (win_cnt_d == WIN_LAST) | last_d;
    rx_ready_d   = (state_d == IDLE) | (run_d & (grp_d == GRP_LAST) & ~tb_due_d);
    acs_en_d     = run_d;
    acs_group_d  = run_d ? grp_d : '0;
    acs_init_d   = run_d & init_pend_d;
    acs_norm_d   = run_d & norm_pend_d;
    sm_wr_en_d   = run_d;
    sm_wr_addr_d = run_d ? {wr_ptr_d, grp_d} : '0;
    tb_start_d   = (state_d == TB_REQ);
    tb_addr_d    = (state_d == TB_REQ) ? AW'(wr_ptr_d - 1'b1) : '0;
    tb_final_d   = (state_d == TB_REQ) & last_d;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grp          <= '0;
      wr_ptr       <= '0;
      win_cnt      <= '0;
      init_pend    <= 1'b1;
      norm_pend    <= 1'b0;
      msb_acc      <= 1'b0;
      last_q       <= 1'b0;
      pair_q       <= '0;
      rx_ready_q   <= 1'b1;
      acs_en_q     <= 1'b0;
      acs_group_q  <= '0;
      acs_init_q   <= 1'b0;
      acs_norm_q   <= 1'b0;
      sm_wr_en_q   <= 1'b0;
      sm_wr_addr_q <= '0;
      tb_start_q   <= 1'b0;
      tb_addr_q    <= '0;
      tb_final_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_d;
      grp          <= grp_d;
      wr_ptr       <= wr_ptr_d;
      win_cnt      <= win_cnt_d;
      init_pend    <= init_pend_d;
      norm_pend    <= norm_pend_d;
      msb_acc      <= msb_acc_d;
      last_q       <= last_d;
      pair_q       <= pair_d;
      rx_ready_q   <= rx_ready_d;
      acs_en_q     <= acs_en_d;
      acs_group_q  <= acs_group_d;
      acs_init_q   <= acs_init_d;
      acs_norm_q   <= acs_norm_d;
      sm_wr_en_q   <= sm_wr_en_d;
      sm_wr_addr_q <= sm_wr_addr_d;
      tb_start_q   <= tb_start_d;
      tb_addr_q    <= tb_addr_d;
      tb_final_q   <= tb_final_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.acs_pair   = pair_q;
  assign bus.acs_en     = acs_en_q;
  assign bus.acs_group  = acs_group_q;
  assign bus.acs_init   = acs_init_q;
  assign bus.acs_norm   = acs_norm_q;
  assign bus.sm_wr_en   = sm_wr_en_q;
  assign bus.sm_wr_addr = sm_wr_addr_q;
  assign bus.tb_start   = tb_start_q;
  assign bus.tb_addr    = tb_addr_q;
  assign bus.tb_final   = tb_final_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_vit_acs_sched.sv
// Bench for vit_acs_sched: symbol-level reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_vit_acs_sched;
  localparam int GROUPS   = 8;
  localparam int TB_DEPTH = 64;
  localparam int TB_LEN   = 32;
  localparam int GW       = 3;
  localparam int AW       = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vit_acs_sched_if #(.GW(GW), .AW(AW)) bus ();

  vit_acs_sched #(.GROUPS(GROUPS), .TB_DEPTH(TB_DEPTH), .TB_LEN(TB_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in symbol terms: the write pointer is simply the number of
  // symbols completed since reset, modulo the memory depth.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_TBREQ = 2, PH_TBWAIT = 3;
  int         m_phase = PH_IDLE;
  int         m_nsym  = 0;
  int         m_win   = 0;
  int         m_cyc   = 0;
  bit         m_first = 1'b1;
  bit         m_norm  = 1'b0;
  bit         m_msb   = 1'b0;
  bit         m_last  = 1'b0;
  logic [1:0] m_pair  = 2'b00;
  bit         chk_en  = 1'b0;

  always @(posedge clk) begin : model
    bit due;
    due = ((m_win + 1) == TB_LEN) || m_last;
    if (rst) begin
      m_phase = PH_IDLE; m_nsym = 0; m_win = 0; m_cyc = 0;
      m_first = 1'b1; m_norm = 1'b0; m_msb = 1'b0; m_last = 1'b0; m_pair = 2'b00;
    end else begin
      case (m_phase)
        PH_IDLE: if (bus.rx_valid === 1'b1) begin
          m_pair = bus.rx_pair; m_last = bus.rx_last; m_cyc = 0; m_phase = PH_RUN;
        end
        PH_RUN: begin
          m_msb = m_msb | (bus.pm_msb === 1'b1);
          if (m_cyc < GROUPS - 1) m_cyc++;
          else begin
            m_nsym++; m_win++; m_first = 1'b0; m_norm = m_msb; m_msb = 1'b0;
            if (due) m_phase = PH_TBREQ;
            else if (bus.rx_valid === 1'b1) begin
              m_pair = bus.rx_pair; m_last = bus.rx_last; m_cyc = 0;
            end else m_phase = PH_IDLE;
          end
        end
        PH_TBREQ: begin
          m_win = 0;
          if (m_last) begin m_first = 1'b1; m_norm = 1'b0; end
          m_phase = PH_TBWAIT;
        end
        default: if (bus.tb_done === 1'b1) m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit run, req, due;
    if (chk_en) begin
      run = (m_phase == PH_RUN);
      req = (m_phase == PH_TBREQ);
      due = ((m_win + 1) == TB_LEN) || m_last;
      chk("rx_ready",   32'(bus.rx_ready),   32'(m_phase == PH_IDLE || (run && m_cyc == GROUPS - 1 && !due)));
      chk("acs_pair",   32'(bus.acs_pair),   32'(m_pair));
      chk("acs_en",     32'(bus.acs_en),     32'(run));
      chk("acs_group",  32'(bus.acs_group),  run ? 32'(m_cyc) : 32'(0));
      chk("acs_init",   32'(bus.acs_init),   32'(run && m_first));
      chk("acs_norm",   32'(bus.acs_norm),   32'(run && m_norm));
      chk("sm_wr_en",   32'(bus.sm_wr_en),   32'(run));
      chk("sm_wr_addr", 32'(bus.sm_wr_addr), run ? 32'((m_nsym % TB_DEPTH) * GROUPS + m_cyc) : 32'(0));
      chk("tb_start",   32'(bus.tb_start),   32'(req));
      chk("tb_addr",    32'(bus.tb_addr),    req ? 32'((m_nsym + TB_DEPTH - 1) % TB_DEPTH) : 32'(0));
      chk("tb_final",   32'(bus.tb_final),   32'(req && m_last));
      chk("busy",       32'(bus.busy),       32'(m_phase != PH_IDLE));
    end
  end

  // Logs of traceback requests and per-symbol first-group values for literal checks.
  int tb_addr_log[$];
  int tb_final_log[$];
  int norm_log[$];
  int init_log[$];
  int addr_log[$];

  always @(negedge clk) begin : capture
    if (bus.tb_start === 1'b1) begin
      tb_addr_log.push_back(int'(bus.tb_addr));
      tb_final_log.push_back(int'(bus.tb_final));
    end
    if (bus.acs_en === 1'b1 && bus.acs_group == 3'd0) begin
      norm_log.push_back(int'(bus.acs_norm));
      init_log.push_back(int'(bus.acs_init));
      addr_log.push_back(int'(bus.sm_wr_addr));
    end
  end

  // pm_msb: either random, or a single pulse at group 5 of a chosen symbol.
  int msb_target = -1;
  bit msb_rand   = 1'b0;
  always @(negedge clk) begin : msb_drv
    if (msb_rand) bus.pm_msb = ($urandom_range(0, 7) == 0);
    else bus.pm_msb = (bus.acs_en === 1'b1 && bus.acs_group == 3'd5 && m_nsym == msb_target);
  end

  // Traceback engine stand-in: answers each request after tb_delay cycles (random if < 0).
  int   tb_delay     = -1;
  logic tb_done_resp = 1'b0;
  logic tb_done_spur = 1'b0;
  assign bus.tb_done = tb_done_resp | tb_done_spur;

  always @(negedge clk) begin : tb_engine
    int d;
    if (bus.tb_start === 1'b1 && rst === 1'b0) begin
      d = (tb_delay > 0) ? tb_delay : int'($urandom_range(1, 6));
      repeat (d) @(negedge clk);
      tb_done_resp = 1'b1;
      @(negedge clk);
      tb_done_resp = 1'b0;
    end
  end

  task automatic send(input logic [1:0] p, input logic l);
    int n;
    n = 0;
    bus.rx_valid = 1'b1; bus.rx_pair = p; bus.rx_last = l;
    while (bus.rx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: rx_ready stuck at %b", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.busy === 1'b0 && bus.rx_ready === 1'b1) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %b rx_ready %b", bus.busy, bus.rx_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_addr_log.delete(); tb_final_log.delete();
    norm_log.delete(); init_log.delete(); addr_log.delete();
  endtask

  task automatic log_chk(input string name, ref int q[$], input int idx, input int exp);
    if (idx < q.size()) chk(name, 32'(q[idx]), 32'(exp));
    else chk({name, "_missing"}, 32'(q.size()), 32'(idx + 1));
  endtask

  initial begin : stim
    int n;
    int ntb;
    bus.rx_valid = 1'b0; bus.rx_pair = 2'b00; bus.rx_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'(1));
    chk("rst_acs_en",   32'(bus.acs_en),   32'(0));
    chk("rst_busy",     32'(bus.busy),     32'(0));
    chk("rst_tb_start", 32'(bus.tb_start), 32'(0));
    rst = 1'b0;

    // Single symbol 2'b10 from reset: groups 0..7 at addresses 0..7 with acs_init.
    send(2'b10, 1'b0);
    for (int i = 0; i < GROUPS; i++) begin
      chk("s1_acs_en",   32'(bus.acs_en),     32'(1));
      chk("s1_group",    32'(bus.acs_group),  32'(i));
      chk("s1_addr",     32'(bus.sm_wr_addr), 32'(i));
      chk("s1_init",     32'(bus.acs_init),   32'(1));
      chk("s1_pair",     32'(bus.acs_pair),   32'(2));
      @(negedge clk);
    end
    chk("s1_busy_after", 32'(bus.busy), 32'(0));
    send(2'b01, 1'b0);
    wait_idle();
    log_chk("s2_addr", addr_log, 1, 8);
    log_chk("s2_init", init_log, 1, 0);

    // 32 back-to-back symbols, slow traceback, 33rd symbol held off meanwhile.
    do_reset();
    tb_delay = 20;
    for (int i = 0; i < 32; i++) send(2'($urandom_range(0, 3)), 1'b0);
    send(2'b11, 1'b0);
    wait_idle();
    tb_delay = -1;
    log_chk("w32_tb_addr",  tb_addr_log,  0, 31);
    log_chk("w32_tb_final", tb_final_log, 0, 0);
    log_chk("w32_next_addr", addr_log, 32, 256);

    // Normalization: pm_msb at group 5 of symbol 3 flags only symbol 4.
    do_reset();
    msb_target = 3;
    for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)), 1'b0);
    wait_idle();
    msb_target = -1;
    log_chk("norm_s3", norm_log, 3, 0);
    log_chk("norm_s4", norm_log, 4, 1);
    log_chk("norm_s5", norm_log, 5, 0);

    // 10-symbol frame, then the first symbol of the next frame.
    do_reset();
    for (int i = 0; i < 10; i++) send(2'($urandom_range(0, 3)), (i == 9));
    send(2'b00, 1'b0);
    wait_idle();
    log_chk("frm_tb_addr",  tb_addr_log,  0, 9);
    log_chk("frm_tb_final", tb_final_log, 0, 1);
    log_chk("frm_init0",    init_log, 0, 1);
    log_chk("frm_init9",    init_log, 9, 0);
    log_chk("frm_init10",   init_log, 10, 1);
    log_chk("frm_addr10",   addr_log, 10, 80);

    // Wrap-around over 96 symbols with random pm_msb.
    do_reset();
    msb_rand = 1'b1;
    for (int i = 0; i < 96; i++) send(2'($urandom_range(0, 3)), 1'b0);
    wait_idle();
    chk("wrap_tb_count", 32'(tb_addr_log.size()), 32'(3));
    log_chk("wrap_tb0", tb_addr_log, 0, 31);
    log_chk("wrap_tb1", tb_addr_log, 1, 63);
    log_chk("wrap_tb2", tb_addr_log, 2, 31);
    log_chk("wrap_addr63", addr_log, 63, 504);
    log_chk("wrap_addr64", addr_log, 64, 0);

    // Random traffic: gaps, frame ends, random traceback latency.
    for (int i = 0; i < 250; i++) begin
      n = int'($urandom_range(0, 3));
      if (n == 3) repeat (int'($urandom_range(1, 4))) @(negedge clk);
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end
    wait_idle();
    msb_rand = 1'b0;

    // Reset in group 4 of a frame-final symbol, with a spurious tb_done.
    send(2'b01, 1'b1);
    n = 0;
    while (bus.acs_group != 3'd4 && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_group", 32'(bus.acs_group), 32'(4));
    rst = 1'b1; tb_done_spur = 1'b1;
    @(negedge clk);
    chk("mid_rx_ready",  32'(bus.rx_ready),   32'(1));
    chk("mid_acs_en",    32'(bus.acs_en),     32'(0));
    chk("mid_group",     32'(bus.acs_group),  32'(0));
    chk("mid_pair",      32'(bus.acs_pair),   32'(0));
    chk("mid_sm_wr_en",  32'(bus.sm_wr_en),   32'(0));
    chk("mid_tb_start",  32'(bus.tb_start),   32'(0));
    chk("mid_busy",      32'(bus.busy),       32'(0));
    rst = 1'b0; tb_done_spur = 1'b0;
    ntb = tb_addr_log.size();
    @(negedge clk);
    tb_done_spur = 1'b1;
    @(negedge clk);
    tb_done_spur = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_tb_after_rst", 32'(tb_addr_log.size()), 32'(ntb));
    chk("idle_after_spur", 32'(bus.busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
